sram_bus_sequencer: RTL



---
 rtl/sram_bus_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sram_bus_sequencer.sv
`default_nettype none
// =============================================================================
// Module : sram_bus_sequencer
// Turns one-cycle re/we pulses into sequenced bus cycles on two async SRAMs.
// Option : SRAM_EXTRA_WAIT_EN stretches W_STROBE and R_SETUP to two cycles.
// Rev    : 1.0
// =============================================================================
module sram_bus_sequencer #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [17:0]       ram_addr1,
  output logic [17:0]       ram_addr2,
  inout  wire  [DATA_W-1:0] ram_data1,
  inout  wire  [DATA_W-1:0] ram_data2,
  output logic              ram1EN,
  output logic              ram2EN,
  output logic              ram1OE,
  output logic              ram2OE,
  output logic              ram1WE,
  output logic              ram2WE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_STROBE = 3'd2,
    S_W_HOLD   = 3'd3,
    S_R_SETUP  = 3'd4,
    S_R_SAMPLE = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_sel;
  logic [ADDR_W-2:0]   r_word;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          r_en_n;
  logic [1:0]          r_oe_n;
  logic [1:0]          r_we_n;
  logic [1:0]          r_drv;
  logic                w_accept_w;
  logic                w_accept_r;
  logic                w_load;
  logic                w_next_sel;
  logic                w_stretch;

`ifdef SRAM_EXTRA_WAIT_EN
  logic r_wait;

  // First cycle in a stretchable state holds; the second moves on.
  assign w_stretch = ((r_state == S_W_STROBE) || (r_state == S_R_SETUP)) && !r_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wait <= 1'b0;
    else      r_wait <= w_stretch;
  end
`else
  assign w_stretch = 1'b0;
`endif

  assign w_accept_w = en && we;
  assign w_accept_r = en && re && !we;
  assign w_load     = ((r_state == S_IDLE) || (r_state == S_DONE)) && (w_accept_w || w_accept_r);
  assign w_next_sel = w_load ? addr[ADDR_W-1] : r_sel;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept_w)      w_next = S_W_SETUP;
        else if (w_accept_r) w_next = S_R_SETUP;
        else                 w_next = S_IDLE;
      end
      S_W_SETUP:  w_next = S_W_STROBE;
      S_W_STROBE: w_next = w_stretch ? S_W_STROBE : S_W_HOLD;
      S_W_HOLD:   w_next = S_DONE;
      S_R_SETUP:  w_next = w_stretch ? S_R_SETUP : S_R_SAMPLE;
      S_R_SAMPLE: w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they appear registered,
  // aligned with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_en_n     <= 2'b11;
      r_oe_n     <= 2'b11;
      r_we_n     <= 2'b11;
      r_drv      <= 2'b00;
    end else begin
      r_state <= w_next;
      r_sel   <= w_next_sel;
      if (w_load) begin
        r_word <= addr[ADDR_W-2:0];
        if (w_accept_w) r_wdata <= data_in;
      end
      if (r_state == S_R_SAMPLE) r_data_out <= r_sel ? ram_data2 : ram_data1;
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      r_en_n <= 2'b11;
      r_oe_n <= 2'b11;
      r_we_n <= 2'b11;
      r_drv  <= 2'b00;
      case (w_next)
        S_W_SETUP, S_W_HOLD: begin
          r_en_n[w_next_sel] <= 1'b0;
          r_drv[w_next_sel]  <= 1'b1;
        end
        S_W_STROBE: begin
          r_en_n[w_next_sel] <= 1'b0;
          r_we_n[w_next_sel] <= 1'b0;
          r_drv[w_next_sel]  <= 1'b1;
        end
        S_R_SETUP, S_R_SAMPLE: begin
          r_en_n[w_next_sel] <= 1'b0;
          r_oe_n[w_next_sel] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_addr1 = 18'(r_word);
  assign ram_addr2 = 18'(r_word);
  assign ram1EN    = r_en_n[0];
  assign ram2EN    = r_en_n[1];
  assign ram1OE    = r_oe_n[0];
  assign ram2OE    = r_oe_n[1];
  assign ram1WE    = r_we_n[0];
  assign ram2WE    = r_we_n[1];
  assign ram_data1 = r_drv[0] ? r_wdata : {DATA_W{1'bz}};
  assign ram_data2 = r_drv[1] ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire
